mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Control stage directly upstream of the MAC neuron datapath. On start it clears
//  the accumulator, streams N_INPUTS (data, weight) pairs from the input/weight
//  memories into the MAC, then adds the bias. It captures the MAC sum and applies
//  optional ReLU. The neuron result is offered on a valid/ready output to the next layer.
// PARAMETERS
//  n        16  word width of data/weight/bias/sum (signed, two's complement)
//  m        8   fraction bits (Qn-m.m); passed through, no arithmetic here
//  N_INPUTS 62  products per neuron, >=1
//  ADDR_W   6   memory address width, 2**ADDR_W >= N_INPUTS
//  USE_RELU 1   1: out = max(sum,0); 0: out = sum
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  start        in   1       begin one neuron evaluation (sampled in IDLE/OUT only)
//  busy         out  1       high from first cycle after accepted start until result handshake
//  mem_addr     out  ADDR_W  shared read address to input and weight memories (1-cycle read latency)
//  mac_clk_en   out  1       MAC accumulate-register enable
//  mac_ctrl_rst out  1       MAC synchronous accumulator clear
//  mac_use_bias out  1       MAC adder selects bias instead of product
//  mac_sum      in   n       MAC adder output (registered sum + selected operand)
//  out_data     out  n       activated neuron result
//  out_valid    out  1       out_data valid; held until out_ready
//  out_ready    in   1       consumer accepts out_data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; busy, mac_clk_en, mac_ctrl_rst, mac_use_bias, out_valid=0;
//   mem_addr=0; out_data=0. All outputs are registered or decoded from state only.
//  FSM IDLE -> CLEAR -> ACC -> BIAS -> OUT -> (IDLE | CLEAR)
//   IDLE : all controls 0; start=1 -> CLEAR.
//   CLEAR: one cycle; mac_ctrl_rst=1, mac_clk_en=0, mem_addr=0; -> ACC, cnt=0.
//   ACC  : N_INPUTS cycles; mac_clk_en=1, mac_use_bias=0; the memory returns the word for index cnt;
//          mem_addr=cnt+1 (prefetch); mem_addr is don't-care on the last ACC cycle (drive cnt+1 truncated).
//          cnt==N_INPUTS-1 -> BIAS.
//   BIAS : one cycle; mac_use_bias=1, mac_clk_en=1; capture out_data<=act(mac_sum) at cycle end;
//          -> OUT.
//   OUT  : out_valid=1, mac_clk_en=0; out_data stable. out_ready=1: out_valid drops next cycle;
//          if start=1 same cycle -> CLEAR (back-to-back, no IDLE bubble), else -> IDLE.
//  Latency: start sampled at edge T -> CLEAR at T+1, out_valid first high at T+N_INPUTS+3.
//  start while busy (CLEAR/ACC/BIAS, or OUT without out_ready) is ignored, not queued.
//  Width: no resizing; mac_sum is n bits. ReLU tests the sign bit only: msb=1 -> 0.
//  cnt width = ADDR_W; no wrap occurs because N_INPUTS <= 2**ADDR_W.
//  N_INPUTS=1: ACC lasts exactly one cycle.
//  Reset mid-operation: immediate return to IDLE. The MAC accumulator is not touched by this
//   block's reset; the next CLEAR guarantees a clean start.
//  out_ready while out_valid=0: no effect.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, CLEAR, ACC, BIAS, OUT, 3-bit) and activation
//   select constants (ACT_NONE, ACT_RELU). Used by the layer controller.
//  No sub-module; ReLU is a local function. Counter and FSM live in one module.
// TESTING (n=16, m=8, 1.0=16'h0100; a behavioural MAC and a 1-cycle-latency memory model are attached)
//  1 Reset: rst=0 mid-ACC -> all outputs 0 next sample, state IDLE; next start runs cleanly.
//  2 N_INPUTS=4, data=weights=1.0, bias=0.5 -> out_data=16'h0480, out_valid at T+7; mem_addr 0,1,2,3.
//  3 Negative sum: data=1.0, weights=-1.0 (N=4), bias=0, USE_RELU=1 -> out_data=0; USE_RELU=0 -> 16'hFC00.
//  4 Backpressure: hold out_ready=0 for 10 cycles -> out_valid, out_data stable and busy=1;
//    start pulses ignored.
//  5 Back-to-back: out_ready=1 and start=1 same cycle -> CLEAR next cycle; second result correct;
//    mac_ctrl_rst pulse width exactly 1.
//  6 N_INPUTS=1, ADDR_W=1: ACC one cycle; out_valid at T+4; mem_addr never exceeds 1.

Source files
------------

// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC neuron control path.
//   seq_state_e : 3-bit sequencer state encoding, also decoded by the layer controller
//   ACT_NONE/ACT_RELU : activation select constants
package mac_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StAcc   = 3'd2,
    StBias  = 3'd3,
    StOut   = 3'd4
  } seq_state_e;

  localparam logic ACT_NONE = 1'b0;
  localparam logic ACT_RELU = 1'b1;

endpackage

// File: rtl/mac_sequencer.sv
// Control stage in front of the MAC neuron datapath. A start clears the accumulator, streams
// N_INPUTS (data, weight) pairs from the shared-address memories into the MAC, adds the bias,
// captures the activated sum and offers it on a valid/ready output.
// Ports:
//   clk, rst       : rising-edge clock, asynchronous active-low reset
//   start          : begin one evaluation (accepted in idle, or in output state with out_ready)
//   busy           : evaluation in progress, until the result handshake
//   mem_addr       : read address to input and weight memories (1-cycle read latency)
//   mac_clk_en     : MAC accumulate-register enable
//   mac_ctrl_rst   : MAC synchronous accumulator clear
//   mac_use_bias   : MAC adder takes bias instead of the product
//   mac_sum        : MAC adder output
//   out_data       : activated neuron result
//   out_valid      : out_data valid, held until out_ready
//   out_ready      : consumer accepts out_data
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned n        = 16,
  parameter int unsigned m        = 8,
  parameter int unsigned N_INPUTS = 62,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned USE_RELU = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mac_clk_en,
  output logic              mac_ctrl_rst,
  output logic              mac_use_bias,
  input  logic [n-1:0]      mac_sum,
  output logic [n-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic              ActSel  = (USE_RELU != 0) ? ACT_RELU : ACT_NONE;
  localparam logic [ADDR_W-1:0] CntLast = ADDR_W'(N_INPUTS - 1);

  // Fraction width only matters to the datapath; kept here so the parameter set matches it.
  logic unused_frac;
  assign unused_frac = (m < n);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [n-1:0]      out_q, out_d;

  // ReLU looks at the sign bit only.
  function automatic logic [n-1:0] act(input logic [n-1:0] s);
    if (ActSel == ACT_RELU && s[n-1]) begin
      return '0;
    end
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StAcc;
      end
      StAcc: begin
        if (cnt_q == CntLast) state_d = StBias;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StBias: begin
        out_d   = act(mac_sum);
        state_d = StOut;
      end
      StOut: begin
        // Handshake with start chains straight into the next clear.
        if (out_ready) state_d = start ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Prefetch: the memory answers one cycle late, so ACC presents the next index.
  assign mem_addr     = (state_q == StAcc) ? cnt_q + 1'b1 : '0;
  assign busy         = (state_q != StIdle);
  assign mac_clk_en   = (state_q == StAcc) || (state_q == StBias);
  assign mac_ctrl_rst = (state_q == StClear);
  assign mac_use_bias = (state_q == StBias);
  assign out_valid    = (state_q == StOut);
  assign out_data     = out_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC + 1-cycle memories around three instances
// (N=4 ReLU, N=4 linear sharing the same MAC, N=1 with 1-bit address), scoreboard of results.
module tb_mac_sequencer;

  localparam int unsigned N = 4;
  localparam logic [4:0] CtlIdle  = 5'b00000;  // {busy, clk_en, ctrl_rst, use_bias, valid}
  localparam logic [4:0] CtlClear = 5'b10100;
  localparam logic [4:0] CtlAcc   = 5'b11000;
  localparam logic [4:0] CtlBias  = 5'b11010;
  localparam logic [4:0] CtlOut   = 5'b10001;

  typedef struct packed {
    logic [15:0] relu;
    logic [15:0] raw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instances A (ReLU) and B (linear) share stimulus and MAC model.
  logic        start = 1'b0, out_ready = 1'b0;
  logic        busy_a, en_a, clr_a, ub_a, ov_a;
  logic        busy_b, en_b, clr_b, ub_b, ov_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] od_a, od_b, sum_ab;
  logic [4:0]  ctl_a, ctl_b;
  logic [15:0] d_mem [64];
  logic [15:0] w_mem [64];
  logic [15:0] bias, rd_d, rd_w, acc;
  exp_t        q[$];

  // Instance C: N_INPUTS=1, ADDR_W=1.
  logic        start_c = 1'b0, ready_c = 1'b0;
  logic        busy_c, en_c, clr_c, ub_c, ov_c;
  logic [0:0]  addr_c;
  logic [15:0] od_c, sum_c;
  logic [4:0]  ctl_c;
  logic [15:0] d_c [2];
  logic [15:0] w_c [2];
  logic [15:0] bias_c, rd_dc, rd_wc, acc_c;
  logic [15:0] qc[$];

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  mac_sequencer #(.n(16), .m(8), .N_INPUTS(N), .ADDR_W(6), .USE_RELU(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .mem_addr(addr_a),
    .mac_clk_en(en_a), .mac_ctrl_rst(clr_a), .mac_use_bias(ub_a), .mac_sum(sum_ab),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready)
  );

  mac_sequencer #(.n(16), .m(8), .N_INPUTS(N), .ADDR_W(6), .USE_RELU(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .mem_addr(addr_b),
    .mac_clk_en(en_b), .mac_ctrl_rst(clr_b), .mac_use_bias(ub_b), .mac_sum(sum_ab),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready)
  );

  mac_sequencer #(.n(16), .m(8), .N_INPUTS(1), .ADDR_W(1), .USE_RELU(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .mem_addr(addr_c),
    .mac_clk_en(en_c), .mac_ctrl_rst(clr_c), .mac_use_bias(ub_c), .mac_sum(sum_c),
    .out_data(od_c), .out_valid(ov_c), .out_ready(ready_c)
  );

  assign ctl_a = {busy_a, en_a, clr_a, ub_a, ov_a};
  assign ctl_b = {busy_b, en_b, clr_b, ub_b, ov_b};
  assign ctl_c = {busy_c, en_c, clr_c, ub_c, ov_c};

  // Memories and MAC accumulators; accumulators are deliberately not reset.
  always @(posedge clk) begin
    rd_d  <= d_mem[addr_a];
    rd_w  <= w_mem[addr_a];
    rd_dc <= d_c[addr_c];
    rd_wc <= w_c[addr_c];
    if (clr_a)     acc   <= '0;
    else if (en_a) acc   <= sum_ab;
    if (clr_c)     acc_c <= '0;
    else if (en_c) acc_c <= sum_c;
  end
  assign sum_ab = acc + (ub_a ? bias : qmul(rd_d, rd_w));
  assign sum_c  = acc_c + (ub_c ? bias_c : qmul(rd_dc, rd_wc));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] d0, input logic [15:0] dstep, input logic [15:0] w,
                      input logic [15:0] b);
    for (int i = 0; i < 64; i++) begin
      d_mem[i] = d0 + dstep * 16'(i);
      w_mem[i] = w;
    end
    bias = b;
  endtask

  task automatic push_expected();
    logic [15:0] s;
    s = bias;
    for (int i = 0; i < int'(N); i++) s = s + qmul(d_mem[i], w_mem[i]);
    q.push_back('{relu: (s[15] ? 16'h0000 : s), raw: s});
  endtask

  task automatic launch();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 50 && ov_a !== 1'b1; i++) tick();
    check({tag, "_valid"}, 32'(ov_a), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_relu"}, 32'(od_a), 32'(e.relu));
      check({tag, "_raw"}, 32'(od_b), 32'(e.raw));
    end
  endtask

  task automatic take(input string tag);
    compare_result(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(ctl_a), 32'(CtlIdle));
  endtask

  // Cycle-by-cycle check of the control timeline from start to result.
  task automatic run_checked(input string tag);
    logic [4:0] ec;
    launch();
    for (int c = 1; c <= int'(N) + 3; c++) begin
      if (c == 1)                ec = CtlClear;
      else if (c <= int'(N) + 1) ec = CtlAcc;
      else if (c == int'(N) + 2) ec = CtlBias;
      else                       ec = CtlOut;
      check({tag, "_ctl_a"}, 32'(ctl_a), 32'(ec));
      check({tag, "_ctl_b"}, 32'(ctl_b), 32'(ec));
      if (c <= int'(N)) begin
        check({tag, "_addr_a"}, 32'(addr_a), 32'(c - 1));
        check({tag, "_addr_b"}, 32'(addr_b), 32'(c - 1));
      end
      if (c < int'(N) + 3) tick();
    end
    take(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_c;
    exp_t e;
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    d_c[0] = '0; d_c[1] = '0; w_c[0] = '0; w_c[1] = '0; bias_c = '0;

    // Reset state
    tick();
    check("rst_ctl_a", 32'(ctl_a), 32'(CtlIdle));
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_od_a", 32'(od_a), 32'd0);
    check("rst_ctl_c", 32'(ctl_c), 32'(CtlIdle));
    rst = 1'b1;
    tick();

    // All-ones data/weights, half bias: 4.5
    load(16'h0100, 16'h0000, 16'h0100, 16'h0080);
    run_checked("ones");

    // Negative sum: ReLU clamps, linear passes -4.0
    load(16'h0100, 16'h0000, 16'hFF00, 16'h0000);
    launch();
    wait_out("neg");
    take("neg");

    // Mixed vector
    load(16'h0080, 16'h0040, 16'h0200, 16'hFFC0);
    run_checked("mix");

    // Reset in the middle of ACC
    load(16'h0100, 16'h0100, 16'hFF80, 16'h0000);
    launch();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ctl_a", 32'(ctl_a), 32'(CtlIdle));
    check("midrst_ctl_b", 32'(ctl_b), 32'(CtlIdle));
    check("midrst_addr", 32'(addr_a), 32'd0);
    check("midrst_od_b", 32'(od_b), 32'd0);
    e = q.pop_back();
    tick();
    rst = 1'b1;
    tick();
    load(16'h0100, 16'h0000, 16'h0100, 16'h0080);
    run_checked("postrst");

    // Backpressure: result held, start ignored
    load(16'h0040, 16'h0020, 16'h0300, 16'h0010);
    launch();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_out("bp");
    e = q[0];
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      check("bp_ctl", 32'(ctl_a), 32'(CtlOut));
      check("bp_od_a", 32'(od_a), 32'(e.relu));
      check("bp_od_b", 32'(od_b), 32'(e.raw));
      tick();
    end
    start = 1'b0;
    take("bp");

    // Back-to-back: handshake and start in the same cycle
    load(16'h0100, 16'h0000, 16'h0100, 16'h0000);
    launch();
    wait_out("b2b1");
    compare_result("b2b1");
    load(16'h0200, 16'hFF00, 16'h0080, 16'h0100);
    push_expected();
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("b2b_clear", 32'(ctl_a), 32'(CtlClear));
    tick();
    check("b2b_clr_width", 32'(ctl_a), 32'(CtlAcc));
    wait_out("b2b2");
    take("b2b2");

    // N_INPUTS=1 instance
    for (int v = 0; v < 2; v++) begin
      d_c[0] = (v == 0) ? 16'h0200 : 16'h0100;
      w_c[0] = (v == 0) ? 16'h0180 : 16'hFE00;
      d_c[1] = 16'h7FFF;
      w_c[1] = 16'h7FFF;
      bias_c = 16'h0040;
      exp_c  = qmul(d_c[0], w_c[0]) + bias_c;
      qc.push_back(exp_c[15] ? 16'h0000 : exp_c);
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      check("n1_clear", 32'(ctl_c), 32'(CtlClear));
      check("n1_addr", 32'(addr_c), 32'd0);
      tick();
      check("n1_acc", 32'(ctl_c), 32'(CtlAcc));
      tick();
      check("n1_bias", 32'(ctl_c), 32'(CtlBias));
      tick();
      check("n1_out", 32'(ctl_c), 32'(CtlOut));
      if (qc.size() != 0) check("n1_data", 32'(od_c), 32'(qc.pop_front()));
      ready_c = 1'b1;
      tick();
      ready_c = 1'b0;
      check("n1_idle", 32'(ctl_c), 32'(CtlIdle));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
